// File: rtl/dual_deque.sv
// Two-channel double-ended queue: each channel is a circular buffer addressable
// at front or back, sharing one data-in / data-out port selected per cycle.
module dual_deque #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chan_sel,
  input  logic             end_sel,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             c0_empty,
  output logic             c0_full,
  output logic             c1_empty,
  output logic             c1_full,
  output logic             error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r   [2][DEPTH];
  logic [AW-1:0]    head_r  [2];
  logic [CW-1:0]    count_r [2];

  logic [AW-1:0] cur_head_s;
  logic [CW-1:0] cur_count_s;
  logic [AW-1:0] back_idx_s;
  logic [AW-1:0] tail_idx_s;
  logic [AW-1:0] head_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic [CW-1:0] cnt0_nxt_s;
  logic [CW-1:0] cnt1_nxt_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_idx_s;
  logic          rd_en_s;
  logic [AW-1:0] rd_idx_s;
  logic          err_s;

  // Decode the operation on the selected channel/end into pointer, storage and error updates.
  always_comb begin
    cur_head_s  = head_r[chan_sel];
    cur_count_s = count_r[chan_sel];
    // Index arithmetic wraps by truncation to AW bits.
    back_idx_s  = cur_head_s + cur_count_s[AW-1:0] - AW'(1'b1);
    tail_idx_s  = cur_head_s + cur_count_s[AW-1:0];
    head_nxt_s  = cur_head_s;
    count_nxt_s = cur_count_s;
    wr_en_s     = 1'b0;
    wr_idx_s    = cur_head_s;
    rd_en_s     = 1'b0;
    rd_idx_s    = cur_head_s;
    err_s       = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (cur_count_s == CNT_FULL) begin
          err_s = 1'b1;
        end else begin
          wr_en_s     = 1'b1;
          count_nxt_s = cur_count_s + CW'(1'b1);
          if (end_sel) begin
            wr_idx_s = tail_idx_s;
          end else begin
            wr_idx_s   = cur_head_s - AW'(1'b1);
            head_nxt_s = cur_head_s - AW'(1'b1);
          end
        end
      end
      2'b01: begin
        if (cur_count_s == {CW{1'b0}}) begin
          err_s = 1'b1;
        end else begin
          rd_en_s     = 1'b1;
          count_nxt_s = cur_count_s - CW'(1'b1);
          if (end_sel) begin
            rd_idx_s = back_idx_s;
          end else begin
            rd_idx_s   = cur_head_s;
            head_nxt_s = cur_head_s + AW'(1'b1);
          end
        end
      end
      2'b11: begin
        // Exchange: read the end element and overwrite the same slot; legal even when full.
        if (cur_count_s == {CW{1'b0}}) begin
          err_s = 1'b1;
        end else begin
          rd_en_s  = 1'b1;
          wr_en_s  = 1'b1;
          rd_idx_s = end_sel ? back_idx_s : cur_head_s;
          wr_idx_s = end_sel ? back_idx_s : cur_head_s;
        end
      end
      default: begin
        err_s = 1'b0;
      end
    endcase
    cnt0_nxt_s = chan_sel ? count_r[0] : count_nxt_s;
    cnt1_nxt_s = chan_sel ? count_nxt_s : count_r[1];
  end

  // Pointer, counter and registered output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r[0]  <= {AW{1'b0}};
      head_r[1]  <= {AW{1'b0}};
      count_r[0] <= {CW{1'b0}};
      count_r[1] <= {CW{1'b0}};
      data_out   <= {WIDTH{1'b0}};
      error      <= 1'b0;
      c0_empty   <= 1'b1;
      c0_full    <= 1'b0;
      c1_empty   <= 1'b1;
      c1_full    <= 1'b0;
    end else begin
      head_r[chan_sel]  <= head_nxt_s;
      count_r[chan_sel] <= count_nxt_s;
      if (rd_en_s) begin
        data_out <= mem_r[chan_sel][rd_idx_s];
      end
      error    <= err_s;
      c0_empty <= (cnt0_nxt_s == {CW{1'b0}});
      c0_full  <= (cnt0_nxt_s == CNT_FULL);
      c1_empty <= (cnt1_nxt_s == {CW{1'b0}});
      c1_full  <= (cnt1_nxt_s == CNT_FULL);
    end
  end

  // Storage write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_s) begin
      mem_r[chan_sel][wr_idx_s] <= data_in;
    end
  end

endmodule

// File: tb/tb_dual_deque.sv
// Directed, table-driven bench for dual_deque (WIDTH=8, DEPTH=8).
module tb_dual_deque;

  logic       clk;
  logic       rst_n;
  logic       chan_sel;
  logic       end_sel;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       c0_empty, c0_full, c1_empty, c1_full, error;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       chan;
    logic       endq;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [7:0] dout;
    logic       c0e, c0f, c1e, c1f, err;
  } vec_t;

  vec_t vecs[$];

  dual_deque #(.WIDTH(8), .DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .chan_sel (chan_sel),
    .end_sel  (end_sel),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .c0_empty (c0_empty),
    .c0_full  (c0_full),
    .c1_empty (c1_empty),
    .c1_full  (c1_full),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(string nm, logic r, logic c, logic e, logic pu, logic po,
                              logic [7:0] d, logic [7:0] od,
                              logic c0e, logic c0f, logic c1e, logic c1f, logic er);
    vec_t v;
    v.name = nm; v.rst_n = r; v.chan = c; v.endq = e; v.push = pu; v.pop = po;
    v.din = d; v.dout = od; v.c0e = c0e; v.c0f = c0f; v.c1e = c1e; v.c1f = c1f; v.err = er;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic r, logic c, logic e, logic pu, logic po, logic [7:0] d);
    rst_n = r; chan_sel = c; end_sel = e; push = pu; pop = po; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [7:0] od, logic c0e, logic c0f,
                       logic c1e, logic c1f, logic er);
    logic [4:0] got_f, exp_f;
    got_f = {c0_empty, c0_full, c1_empty, c1_full, error};
    exp_f = {c0e, c0f, c1e, c1f, er};
    n_tests++;
    if (data_out !== od || got_f !== exp_f) begin
      n_fail++;
      $display("FAIL %s: got dout=%h c0e/c0f/c1e/c1f/err=%b, required dout=%h c0e/c0f/c1e/c1f/err=%b",
               nm, data_out, got_f, od, exp_f);
    end
  endtask

  initial begin
    logic [7:0] prev;
    rst_n = 1'b0; chan_sel = 1'b0; end_sel = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;

    // Reset with a push pending; nothing may be written.
    add("rst0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add("rst1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Deque order on ch0.
    add("pb11", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("pb22", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("pf33", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("popf", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("popb", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("popf_last", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Underflow and empty exchange on ch0.
    add("underflow", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    add("err_clear", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add("xchg_empty", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // Fill ch1, overflow, drain from the front.
    for (int i = 1; i <= 8; i++)
      add($sformatf("fill%0d", i), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'(i), 8'h11,
          1'b1, 1'b0, 1'b0, (i == 8), 1'b0);
    add("overflow", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    add("idle_full", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++)
      add($sformatf("drain%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'(i),
          1'b1, 1'b0, (i == 8), 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++)
      add($sformatf("refill%0d", i), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'(i), 8'h08,
          1'b1, 1'b0, 1'b0, (i == 8), 1'b0);
    // Exchange on a full channel, then read back both ends.
    add("xchg_back", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 8'h08, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add("pop_aa", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add("pop_01", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add("xchg_front", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hBB, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add("pop_bb", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst_n, vecs[k].chan, vecs[k].endq, vecs[k].push, vecs[k].pop, vecs[k].din);
      check(vecs[k].name, vecs[k].dout, vecs[k].c0e, vecs[k].c0f, vecs[k].c1e, vecs[k].c1f, vecs[k].err);
    end

    // Wrap-around: push front then pop back on ch0; ch1 still holds 3..7.
    prev = 8'hBB;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'(i));
      check($sformatf("wrap_push%0d", i), prev, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      check($sformatf("wrap_pop%0d", i), 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      prev = 8'(i);
    end

    // Reset arriving together with a pop on a 3-entry channel.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA2);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA3);
    check("mid_pre", 8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("mid_rst", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    check("post_rst_pop_ch1", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    check("post_rst_push_pop", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_deque.md
# dual_deque

Parametrised two-channel double-ended queue, the successor to `dual_stack` in the tile top level. Each channel is an independent circular buffer of `DEPTH` words of `WIDTH` bits that can be pushed or popped at either end. Both channels share one data-in and one data-out port, selected per cycle. An exchange operation and a sticky-free error pulse are added to the plain stack behaviour. In the top wrapper, `uio_in[3]` drives `end_sel` and `uio_out[3]` carries `error`; the remaining pins keep their existing mapping.

## Interface
- `WIDTH`, default 8: data word width in bits, ≥1.
- `DEPTH`, default 8: entries per channel; power of two, ≥2.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `chan_sel`  in  1  channel addressed this cycle: 0 = channel 0, 1 = channel 1.
- `end_sel`  in  1  end addressed: 0 = front, 1 = back.
- `push`  in  1  write `data_in` at the selected end.
- `pop`  in  1  read the selected end into `data_out` and remove it.
- `data_in`  in  WIDTH  push data.
- `data_out`  out  WIDTH  registered; last successfully popped or exchanged word.
- `c0_empty`, `c0_full`, `c1_empty`, `c1_full`  out  1 each  registered per-channel flags.
- `error`  out  1  one-cycle pulse for a rejected operation.

## Operation
- Per-channel state:
  - `head`: clog2(DEPTH) bits; index of the front element.
  - `count`: clog2(DEPTH)+1 bits, range 0..DEPTH.
  - Storage: DEPTH×WIDTH.
- Index arithmetic is modulo DEPTH; wrap-around happens by natural truncation. Back element index = head+count−1.
- Only the selected channel changes state; the other channel holds.
- Operations on the selected channel and end:
  - Push front: head←head−1, mem[head−1]←data_in, count+1.
  - Push back: mem[head+count]←data_in, count+1.
  - Pop front: data_out←mem[head], head+1, count−1.
  - Pop back: data_out←mem[head+count−1], count−1.
  - Push and pop together (exchange): data_out←the element at the selected end, then that slot←data_in. head and count are unchanged. Exchange is legal when the channel is full.
- Rejections. State, storage and data_out all hold, and error=1 for one cycle, when:
  - push alone while count==DEPTH;
  - pop alone while count==0;
  - exchange while count==0.
- Neither push nor pop: no-op, error=0.
- Flags are registered and reflect count after the update: empty = (count==0), full = (count==DEPTH).
- data_out changes only on a successful pop or exchange. It holds across idle cycles and across channel switches.
- Pop-front and pop-back on a 1-element channel return the same word and leave the channel empty; head is unchanged on pop-back.

## Timing
- Synchronous reset: at the first rising edge with rst_n=0:
  - head=0, count=0 on both channels;
  - data_out=0, error=0;
  - c0_empty=c1_empty=1, c0_full=c1_full=0.
- Storage contents are not reset.
- Reset takes priority over any simultaneous push or pop. An operation in flight is discarded.
- Inputs are sampled on the rising edge.
- data_out, flags and error are valid one cycle after the sampling edge. Pop latency = 1 cycle.
- Back-to-back operations at one per cycle, to any channel or end, with no bubbles.
- A push followed next cycle by a pop at either end returns the pushed word when the channel was empty before the push.
- No combinational path from inputs to outputs.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with push=1 → data_out=0, both empty=1, both full=0, error=0; no entry written.
- **Deque order (ch0, DEPTH=8):**
  - push back 0x11, 0x22, then push front 0x33;
  - pop front, pop back, pop front → data_out 0x33, 0x22, 0x11 on consecutive cycles;
  - c0_empty=1 after the last pop; ch1 flags unchanged throughout.
- **Full/overflow:**
  - push back 0x01..0x08 on ch1 → c1_full=1;
  - ninth push 0xFF → error pulse, contents intact;
  - pop front ×8 → 0x01..0x08.
- **Empty/underflow and exchange:**
  - pop on empty ch0 → error=1, data_out holds its prior value;
  - exchange on empty → error=1;
  - on full ch1 holding 0x01..0x08, exchange at back with 0xAA → data_out=0x08, count still 8;
  - subsequent pop back → 0xAA.
- **Wrap-around:**
  - alternate push front/pop back 20 times on ch0 with values 0x00..0x13 → each pop returns the word just pushed;
  - head wraps without error.
- **Mid-operation reset:** with ch0 holding 3 entries, assert rst_n=0 together with pop → after the edge c0_empty=1, data_out=0, error=0.
